// File: rtl/divider_restoring_seq_pkg.sv
// rtl/divider_restoring_seq_pkg.sv - shared types and helpers for the restoring divider
// Purpose: FSM state encoding and the iteration-counter width helper.
// Ports: none (package).
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width able to hold 0..width-1; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/divider_restoring_seq_if.sv
// rtl/divider_restoring_seq_if.sv - start/done request and result bundle for the divider
// Purpose: groups the divide request and result signals.
// Ports: start, dividend, divisor (requester -> divider);
//        busy, done, quotient, remainder, div_by_zero (divider -> requester).
interface divider_restoring_seq_if #(
  parameter int WIDTH = 4
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/divider_restoring_seq_step.sv
// rtl/divider_restoring_seq_step.sv - one restoring-division iteration (combinational)
// Purpose: shifts the next dividend bit into the partial remainder, trial-subtracts
//          the divisor and restores on borrow.
// Ports: r (partial remainder), q_msb (bit shifted in), divisor;
//        r_next (updated remainder), q_bit (quotient bit), borrow (trial went negative).
module divider_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit,
  output logic             borrow
);

  logic [WIDTH:0]   r_shift;
  logic [WIDTH+1:0] diff;
  logic             unused_diff_msb;

  // R' can reach 2*divisor-1, so it needs WIDTH+1 bits; one more bit holds the borrow.
  assign r_shift = {r, q_msb};
  assign diff    = {1'b0, r_shift} - {2'b00, divisor};
  assign borrow  = diff[WIDTH+1];
  assign q_bit   = ~borrow;

  // Either way the result is below the divisor, so the low WIDTH bits are exact.
  assign r_next  = borrow ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0];

  assign unused_diff_msb = diff[WIDTH];

endmodule

// File: rtl/divider_restoring_seq.sv
// rtl/divider_restoring_seq.sv - iterative unsigned restoring divider, one quotient bit per clock
// Purpose: dividend = quotient*divisor + remainder, behind a start/done handshake.
// Ports: clk, rst_n (async active-low); bus (slave): start, dividend, divisor in;
//        busy, done, quotient, remainder, div_by_zero out.
module divider_restoring_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  divider_restoring_seq_if.slave   bus
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] r_q, q_q, divisor_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             dbz_q;
  logic [CNT_W-1:0] count;
  logic             accept, last_iter;

  logic [WIDTH-1:0] step_r_next;
  logic             step_q_bit;
  logic             step_borrow;
  logic [WIDTH-1:0] q_shift;
  logic             unused_borrow;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_q),
    .q_msb   (q_q[WIDTH-1]),
    .divisor (divisor_q),
    .r_next  (step_r_next),
    .q_bit   (step_q_bit),
    .borrow  (step_borrow)
  );

  assign unused_borrow = step_borrow;
  assign q_shift       = {q_q[WIDTH-2:0], step_q_bit};
  assign last_iter     = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      // DONE accepts a new request exactly like IDLE, giving back-to-back operation.
      IDLE, DONE: begin
        state_next = IDLE;
        if (bus.start) begin
          accept     = 1'b1;
          state_next = (bus.divisor == '0) ? DONE : CALC;
        end
      end
      CALC:    if (last_iter) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q         <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      count       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (accept) begin
      if (bus.divisor == '0) begin
        // Results publish immediately; the working registers are not needed.
        quotient_q  <= '1;
        remainder_q <= bus.dividend;
        dbz_q       <= 1'b1;
      end else begin
        r_q       <= '0;
        q_q       <= bus.dividend;
        divisor_q <= bus.divisor;
        count     <= '0;
      end
    end else if (state == CALC) begin
      r_q   <= step_r_next;
      q_q   <= q_shift;
      count <= count + CNT_W'(1);
      if (last_iter) begin
        quotient_q  <= q_shift;
        remainder_q <= step_r_next;
        dbz_q       <= 1'b0;
      end
    end
  end

  assign bus.busy        = (state == CALC);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_restoring_seq.sv
// tb/tb_divider_restoring_seq.sv - scoreboard bench for the restoring divider
module tb_divider_restoring_seq;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       z;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  divider_restoring_seq_if #(.WIDTH(4)) bus ();

  divider_restoring_seq #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops one expected result per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      check("busy_done_exclusive", {31'd0, bus.busy}, 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got q=%0d r=%0d expected no done", bus.quotient, bus.remainder);
      end else begin
        e = sb.pop_front();
        check("quotient",    {28'd0, bus.quotient},    {28'd0, e.q});
        check("remainder",   {28'd0, bus.remainder},   {28'd0, e.r});
        check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.z});
      end
    end
  end

  // One-cycle start pulse; returns #1 after the accepting edge.
  task automatic issue(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] eq, input logic [3:0] er, input logic ez,
                       input bit push);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    if (push) sb.push_back('{eq, er, ez});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges and busy cycles until done is seen, bounded.
  task automatic wait_done(input string name, input int exp_edges, input int exp_busy);
    int edges = 0;
    int busy_cnt = 0;
    while (!bus.done && edges < 40) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk);
      #1;
      edges++;
    end
    check({name, "_latency"}, edges, exp_edges);
    check({name, "_busy_cycles"}, busy_cnt, exp_busy);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"},      {31'd0, bus.busy},        32'd0);
    check({name, "_done"},      {31'd0, bus.done},        32'd0);
    check({name, "_quotient"},  {28'd0, bus.quotient},    32'd0);
    check({name, "_remainder"}, {28'd0, bus.remainder},   32'd0);
    check({name, "_dbz"},       {31'd0, bus.div_by_zero}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    issue(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b1);
    wait_done("d13_3", 4, 4);
    issue(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b1);
    wait_done("d15_1", 4, 4);
    issue(4'd2, 4'd7, 4'd0, 4'd2, 1'b0, 1'b1);
    wait_done("d2_7", 4, 4);
    issue(4'd5, 4'd0, 4'd15, 4'd5, 1'b1, 1'b1);
    wait_done("d5_0", 0, 0);

    // Start while busy is ignored, then back-to-back start held in DONE
    issue(4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 1'b1);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd9;
    bus.divisor  = 4'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("d12_5_ignored", 3, 3);
    bus.start    = 1'b1;
    bus.dividend = 4'd9;
    bus.divisor  = 4'd2;
    sb.push_back('{4'd4, 4'd1, 1'b0});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("d9_2_b2b", 4, 4);

    // Reset in the second CALC cycle aborts without a done pulse
    issue(4'd14, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("post_reset_idle");
    issue(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 1'b1);
    wait_done("d14_3", 4, 4);

    // Exhaustive sweep against a reference model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [3:0] eq, er;
        eq = (b == 0) ? 4'd15 : 4'(a / b);
        er = (b == 0) ? 4'(a) : 4'(a % b);
        issue(4'(a), 4'(b), eq, er, (b == 0), 1'b1);
        wait_done("sweep", (b == 0) ? 0 : 4, (b == 0) ? 0 : 4);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
